mezz_io_bridge: RTL



---
 rtl/mezz_io_bridge_if.sv | 22 ++
 rtl/mezz_io_bridge.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mezz_io_bridge_if.sv
// Connector-side signal bundle for mezz_io_bridge: mode/config and bridged
// channels in, registered channels, activity LEDs and heartbeat out.
interface mezz_io_bridge_if #(
  parameter int CHANNELS = 16
);
  logic [1:0]          MODE;
  logic [CHANNELS-1:0] FILT_MASK;
  logic [CHANNELS-1:0] CH_IN;
  logic [CHANNELS-1:0] CH_OUT;
  logic [3:0]          ACT_LED;
  logic                ALIVE;

  modport master (
    output MODE, FILT_MASK, CH_IN,
    input  CH_OUT, ACT_LED, ALIVE
  );

  modport slave (
    input  MODE, FILT_MASK, CH_IN,
    output CH_OUT, ACT_LED, ALIVE
  );
endinterface

// File: rtl/mezz_io_bridge.sv
// Mezzanine pass-through bridge: synchronises CH_IN, optionally glitch-filters it,
// and drives CH_OUT in pass/filtered/test-pattern/safe modes with activity LEDs.
module mezz_io_bridge #(
  parameter int CHANNELS     = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_LEN     = 8,
  parameter int TEST_DIV     = 20,
  parameter int STRETCH_BITS = 22,
  parameter int HB_BITS      = 24
) (
  input logic              CLK_50,
  input logic              RESET_N,
  mezz_io_bridge_if.slave  io
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int GW = CHANNELS / 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_FILT = 2'd1,
    MODE_TEST = 2'd2,
    MODE_SAFE = 2'd3
  } mode_e;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync;
  logic [1:0]          mode_m;
  mode_e               mode_s;
  logic [CHANNELS-1:0] filt;
  logic [CW-1:0]       cnt [CHANNELS];
  logic [CHANNELS-1:0] pattern;
  logic [TEST_DIV-1:0] tdiv;
  logic [CHANNELS-1:0] ch_out_q;
  logic [CHANNELS-1:0] sync_prev;
  logic [CHANNELS-1:0] changed;
  logic [STRETCH_BITS-1:0] stretch [4];
  logic [3:0]          act_led_q;
  logic [HB_BITS-1:0]  hb;
  logic                alive_q;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign changed = sync ^ sync_prev;

  assign io.CH_OUT  = ch_out_q;
  assign io.ACT_LED = act_led_q;
  assign io.ALIVE   = alive_q;

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      mode_m <= '0;
      mode_s <= MODE_PASS;
    end else begin
      sync_q[0] <= io.CH_IN;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      mode_m <= io.MODE;
      mode_s <= mode_e'(mode_m);
    end
  end

  // Filter runs regardless of mode so entering filtered mode never glitches.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      filt <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sync[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt[i] <= sync[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pattern <= CHANNELS'(1);
      tdiv    <= '0;
    end else if (mode_s != MODE_TEST) begin
      pattern <= CHANNELS'(1);
      tdiv    <= '0;
    end else begin
      tdiv <= tdiv + 1'b1;
      if (&tdiv) pattern <= {pattern[CHANNELS-2:0], pattern[CHANNELS-1]};
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ch_out_q <= '0;
    end else begin
      case (mode_s)
        MODE_PASS: ch_out_q <= sync;
        MODE_FILT: ch_out_q <= (io.FILT_MASK & filt) | (~io.FILT_MASK & sync);
        MODE_TEST: ch_out_q <= pattern;
        MODE_SAFE: ch_out_q <= '0;
        default:   ch_out_q <= '0;
      endcase
    end
  end

  // Any edge in a group reloads its stretcher, so bursts keep the LED lit.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_prev <= '0;
      act_led_q <= '0;
      for (int unsigned g = 0; g < 4; g++) stretch[g] <= '0;
    end else begin
      sync_prev <= sync;
      for (int unsigned g = 0; g < 4; g++) begin
        if (|changed[g*GW +: GW])
          stretch[g] <= '1;
        else if (stretch[g] != '0)
          stretch[g] <= stretch[g] - 1'b1;
        act_led_q[g] <= (stretch[g] != '0);
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hb      <= '0;
      alive_q <= 1'b0;
    end else begin
      hb <= hb + 1'b1;
      if (&hb) alive_q <= ~alive_q;
    end
  end
endmodule
